// File: rtl/powerup_manager_if.sv
// ---------------------------------------------------------------------------
// powerup_manager_if
//
// Purpose:
//   Groups the register-file inputs and the power-up outputs of the power-up
//   sequencer into one bundle. The register-file side drives the game
//   context. The manager drives the offer/active flags and the winner latch.
//
// Signals:
//   screen_state  [31:0]  regfile r28, current screen id
//   score         [31:0]  regfile r16, unsigned score
//   clicks        [31:0]  regfile r26, button click count
//   name          [15:0]  player initials {letter, 8'h00}
//   pickup_n              VGA pickup trigger, active-low level
//   power_on              icon visible / offer pending or power-up in use
//   offer_flags   [2:0]   one-hot offered power {ycontrol, slow, bounce}
//   active_flags  [2:0]   one-hot active power  {ycontrol, slow, bounce}
//   state         [1:0]   0 IDLE, 1 ARMED, 2 ACTIVE, 3 EXPIRED
//   expired               one-cycle pulse when a power-up runs out
//   winner_score  [7:0]   best score[14:7] seen on the end screen
//   winner_name   [15:0]  name latched together with winner_score
//
// Modports:
//   master  register-file / VGA side (drives the game context)
//   slave   powerup_manager side (drives the power-up status)
// ---------------------------------------------------------------------------
interface powerup_manager_if;

  logic [31:0] screen_state;
  logic [31:0] score;
  logic [31:0] clicks;
  logic [15:0] name;
  logic        pickup_n;

  logic        power_on;
  logic [2:0]  offer_flags;
  logic [2:0]  active_flags;
  logic [1:0]  state;
  logic        expired;
  logic [7:0]  winner_score;
  logic [15:0] winner_name;

  modport master (
    output screen_state,
    output score,
    output clicks,
    output name,
    output pickup_n,
    input  power_on,
    input  offer_flags,
    input  active_flags,
    input  state,
    input  expired,
    input  winner_score,
    input  winner_name
  );

  modport slave (
    input  screen_state,
    input  score,
    input  clicks,
    input  name,
    input  pickup_n,
    output power_on,
    output offer_flags,
    output active_flags,
    output state,
    output expired,
    output winner_score,
    output winner_name
  );

endinterface

// File: rtl/powerup_manager.sv
// ---------------------------------------------------------------------------
// powerup_manager
//
// Purpose:
//   Power-up sequencer sitting between the register file and the VGA,
//   regfile and audio consumers. While in game it offers a power-up when
//   the click cadence lines up. The score picks which power. The power-up
//   becomes active when the VGA pickup strobe falls (bird touches the icon).
//   It then stays active for DURATION score units. On the end screen it
//   also keeps the best score[14:7] and the matching player name for the
//   LCD stage.
//
// Ports:
//   clock    system clock (10 MHz PLL domain)
//   resetn   asynchronous active-low reset
//   bus      powerup_manager_if.slave, which carries:
//              inputs : screen_state, score, clicks, name, pickup_n
//              outputs: power_on, offer_flags, active_flags, state,
//                       expired, winner_score, winner_name
//
// Parameters:
//   CLICK_MOD    offer check fires when (clicks+1) mod CLICK_MOD == 0
//   DURATION     score units a power-up stays active
//   SCREEN_GAME  screen_state value for in-game
//   SCREEN_END   screen_state value for the end screen
//   ARM_TIMEOUT  cycles an offer waits for pickup (POWERUP_TIMEOUT_EN only)
//
// Configuration:
//   POWERUP_TIMEOUT_EN  when defined, an unclaimed offer is withdrawn after
//                       ARM_TIMEOUT cycles in ARMED. When undefined, an
//                       offer waits until pickup or screen exit.
//
// All outputs are registered, so each output follows its inputs one
// cycle later.
// ---------------------------------------------------------------------------
module powerup_manager #(
  parameter int CLICK_MOD   = 25,
  parameter int DURATION    = 400,
  parameter int SCREEN_GAME = 3,
  parameter int SCREEN_END  = 4,
  parameter int ARM_TIMEOUT = 20000000
) (
  input  logic             clock,
  input  logic             resetn,
  powerup_manager_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    ACTIVE  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [31:0] CLICK_MOD_W = 32'(CLICK_MOD);
  localparam logic [31:0] GAME_W      = 32'(SCREEN_GAME);
  localparam logic [31:0] END_W       = 32'(SCREEN_END);
  localparam logic [32:0] DURATION_W  = 33'(DURATION);
`ifdef POWERUP_TIMEOUT_EN
  localparam logic [31:0] ARM_LAST    = 32'(ARM_TIMEOUT - 1);
`endif

  state_t      state_q, state_d;
  logic        power_q, power_d;
  logic [2:0]  offer_q, offer_d;
  logic [2:0]  active_q, active_d;
  logic        expired_q, expired_d;
  logic [31:0] start_q, start_d;
  logic [7:0]  winner_score_q, winner_score_d;
  logic [15:0] winner_name_q, winner_name_d;
  logic        hist_q;
`ifdef POWERUP_TIMEOUT_EN
  logic [31:0] count_q, count_d;
`endif

  logic [31:0] clicks_inc;
  logic        offer_hit;
  logic        pickup_fall;
  logic        span_done;
  logic [7:0]  score_hi;
  logic [2:0]  offer_sel;

  // Decode the qualifying conditions from the current inputs.
  // The click increment wraps in 32 bits, so clicks = 32'hFFFF_FFFF becomes 0,
  // and 0 mod CLICK_MOD is 0. The expiry compare is done in 33 bits so that
  // start_score + DURATION can never wrap past a large score.
  always_comb begin
    clicks_inc  = bus.clicks + 32'd1;
    offer_hit   = (clicks_inc % CLICK_MOD_W) == 32'd0;
    pickup_fall = hist_q & ~bus.pickup_n;
    span_done   = {1'b0, bus.score} >= ({1'b0, start_q} + DURATION_W);
    score_hi    = bus.score[14:7];
    case (bus.score[1:0])
      2'd1:    offer_sel = 3'b001;
      2'd2:    offer_sel = 3'b010;
      2'd3:    offer_sel = 3'b100;
      default: offer_sel = 3'b000;
    endcase
  end

  // Next-state and next-output logic.
  // Leaving the game screen takes priority over every FSM state. An offer
  // that lines up with a screen exit in the same cycle is therefore dropped.
  always_comb begin
    state_d        = state_q;
    power_d        = power_q;
    offer_d        = offer_q;
    active_d       = active_q;
    expired_d      = 1'b0;
    start_d        = start_q;
    winner_score_d = winner_score_q;
    winner_name_d  = winner_name_q;
`ifdef POWERUP_TIMEOUT_EN
    count_d        = count_q;
`endif

    if (bus.screen_state != GAME_W) begin
      state_d  = IDLE;
      power_d  = 1'b0;
      offer_d  = 3'b000;
      active_d = 3'b000;
      // A strict compare keeps the first player who reached a tied score.
      if ((bus.screen_state == END_W) && (score_hi > winner_score_q)) begin
        winner_score_d = score_hi;
        winner_name_d  = bus.name;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (offer_hit && (offer_sel != 3'b000)) begin
            state_d = ARMED;
            power_d = 1'b1;
            offer_d = offer_sel;
`ifdef POWERUP_TIMEOUT_EN
            count_d = 32'd0;
`endif
          end
        end

        ARMED: begin
          // An edge on the timeout's last cycle still wins.
          if (pickup_fall) begin
            state_d  = ACTIVE;
            active_d = offer_q;
            start_d  = bus.score;
`ifdef POWERUP_TIMEOUT_EN
          end else if (count_q == ARM_LAST) begin
            state_d = IDLE;
            power_d = 1'b0;
            offer_d = 3'b000;
          end else begin
            count_d = count_q + 32'd1;
`endif
          end
        end

        ACTIVE: begin
          if (span_done) begin
            state_d   = EXPIRED;
            power_d   = 1'b0;
            offer_d   = 3'b000;
            active_d  = 3'b000;
            expired_d = 1'b1;
          end
        end

        EXPIRED: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers. The pickup history resets high, so a
  // pickup_n that is already low out of reset is not taken as an edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      power_q        <= 1'b0;
      offer_q        <= 3'b000;
      active_q       <= 3'b000;
      expired_q      <= 1'b0;
      start_q        <= 32'd0;
      winner_score_q <= 8'd0;
      winner_name_q  <= 16'd0;
      hist_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      power_q        <= power_d;
      offer_q        <= offer_d;
      active_q       <= active_d;
      expired_q      <= expired_d;
      start_q        <= start_d;
      winner_score_q <= winner_score_d;
      winner_name_q  <= winner_name_d;
      hist_q         <= bus.pickup_n;
    end
  end

`ifdef POWERUP_TIMEOUT_EN
  // Offer timeout counter. It is cleared when the FSM enters ARMED.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end
`endif

  assign bus.state        = state_q;
  assign bus.power_on     = power_q;
  assign bus.offer_flags  = offer_q;
  assign bus.active_flags = active_q;
  assign bus.expired      = expired_q;
  assign bus.winner_score = winner_score_q;
  assign bus.winner_name  = winner_name_q;

endmodule

// File: tb/tb_powerup_manager.sv
// ---------------------------------------------------------------------------
// tb_powerup_manager
//
// Self-checking bench for powerup_manager. Each applied input vector is also
// fed to a behavioural reference model. The model's predicted outputs are
// queued and then compared with the DUT one clock later. Directed sequences
// cover reset, arming, pickup, expiry, screen exit, click wrap and the
// winner latch. A random phase follows. With POWERUP_TIMEOUT_EN the DUT is
// built with ARM_TIMEOUT = 8 and the offer timeout is exercised.
// ---------------------------------------------------------------------------
module tb_powerup_manager;

  localparam int MODEL_ARM_TIMEOUT = 8;
`ifdef POWERUP_TIMEOUT_EN
  localparam int DUT_ARM_TIMEOUT = MODEL_ARM_TIMEOUT;
`else
  localparam int DUT_ARM_TIMEOUT = 20000000;
`endif

  logic clock;
  logic resetn;

  powerup_manager_if bus ();

  powerup_manager #(.ARM_TIMEOUT(DUT_ARM_TIMEOUT)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  st;
    logic        pw;
    logic [2:0]  of;
    logic [2:0]  ac;
    logic        ex;
    logic [7:0]  ws;
    logic [15:0] wn;
  } expect_t;

  expect_t sbq[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int          m_state;
  bit          m_power;
  bit [2:0]    m_offer;
  bit [2:0]    m_active;
  bit          m_exp;
  bit [7:0]    m_ws;
  bit [15:0]   m_wn;
  bit [31:0]   m_start;
  bit          m_hist;
  int          m_cnt;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_state  = 0;
    m_power  = 0;
    m_offer  = 0;
    m_active = 0;
    m_exp    = 0;
    m_ws     = 0;
    m_wn     = 0;
    m_start  = 0;
    m_hist   = 1;
    m_cnt    = 0;
  endtask

  task automatic modelStep(input bit [31:0] scr, input bit [31:0] sc,
                           input bit [31:0] ck, input bit [15:0] nm,
                           input bit pk);
    bit        fall;
    bit [31:0] inc;
    bit [7:0]  hi;
    bit [32:0] lhs;
    bit [32:0] rhs;
    fall   = m_hist && !pk;
    m_hist = pk;
    m_exp  = 0;
    inc    = ck + 32'd1;
    hi     = sc[14:7];
    if (scr != 32'd3) begin
      m_state  = 0;
      m_power  = 0;
      m_offer  = 0;
      m_active = 0;
      if (scr == 32'd4 && hi > m_ws) begin
        m_ws = hi;
        m_wn = nm;
      end
    end else begin
      case (m_state)
        0: if ((inc % 32'd25) == 32'd0 && sc[1:0] != 2'b00) begin
             m_state = 1;
             m_power = 1;
             m_offer = (sc[1:0] == 2'd1) ? 3'b001 :
                       (sc[1:0] == 2'd2) ? 3'b010 : 3'b100;
             m_cnt   = 0;
           end
        1: begin
             if (fall) begin
               m_state  = 2;
               m_active = m_offer;
               m_start  = sc;
             end
`ifdef POWERUP_TIMEOUT_EN
             else if (m_cnt == MODEL_ARM_TIMEOUT - 1) begin
               m_state = 0;
               m_power = 0;
               m_offer = 0;
             end else begin
               m_cnt++;
             end
`endif
           end
        2: begin
             lhs = {1'b0, sc};
             rhs = {1'b0, m_start} + 33'd400;
             if (lhs >= rhs) begin
               m_state  = 3;
               m_power  = 0;
               m_offer  = 0;
               m_active = 0;
               m_exp    = 1;
             end
           end
        default: m_state = 0;
      endcase
    end
  endtask

  // Drive one vector on the falling edge, queue the model's prediction,
  // then compare just after the next rising edge.
  task automatic applyStimulus(input logic [31:0] scr, input logic [31:0] sc,
                               input logic [31:0] ck, input logic [15:0] nm,
                               input logic pk);
    expect_t e;
    expect_t got;
    @(negedge clock);
    bus.screen_state = scr;
    bus.score        = sc;
    bus.clicks       = ck;
    bus.name         = nm;
    bus.pickup_n     = pk;
    modelStep(scr, sc, ck, nm, pk);
    e.st = 2'(m_state);
    e.pw = m_power;
    e.of = m_offer;
    e.ac = m_active;
    e.ex = m_exp;
    e.ws = m_ws;
    e.wn = m_wn;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    got = sbq.pop_front();
    checkOutput("state",        32'(bus.state),        32'(got.st));
    checkOutput("power_on",     32'(bus.power_on),     32'(got.pw));
    checkOutput("offer_flags",  32'(bus.offer_flags),  32'(got.of));
    checkOutput("active_flags", 32'(bus.active_flags), 32'(got.ac));
    checkOutput("expired",      32'(bus.expired),      32'(got.ex));
    checkOutput("winner_score", 32'(bus.winner_score), 32'(got.ws));
    checkOutput("winner_name",  32'(bus.winner_name),  32'(got.wn));
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    logic [31:0] scr;
    logic [31:0] ck;

    resetn           = 1'b0;
    bus.screen_state = 32'd0;
    bus.score        = 32'd0;
    bus.clicks       = 32'd0;
    bus.name         = 16'd0;
    bus.pickup_n     = 1'b1;
    modelReset();
    #1;
    checkOutput("reset_state", 32'(bus.state), 32'd0);
    checkOutput("reset_power", 32'(bus.power_on), 32'd0);
    checkOutput("reset_winner", 32'(bus.winner_score), 32'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    $display("[TB] reset released");

    // Arming: score[1:0]==0 must not arm; score=5 arms bounce
    applyStimulus(32'd3, 32'd4, 32'd24, 16'd0, 1'b1);
    checkOutput("noarm_state", 32'(bus.state), 32'd0);
    applyStimulus(32'd3, 32'd5, 32'd24, 16'd0, 1'b1);
    checkOutput("arm_state", 32'(bus.state), 32'd1);
    checkOutput("arm_offer", 32'(bus.offer_flags), 32'b001);

    // Pickup, held-low, retrigger and expiry
    applyStimulus(32'd3, 32'd100, 32'd0, 16'd0, 1'b1);
    applyStimulus(32'd3, 32'd100, 32'd0, 16'd0, 1'b0);
    checkOutput("pick_state", 32'(bus.state), 32'd2);
    checkOutput("pick_active", 32'(bus.active_flags), 32'b001);
    repeat (3) applyStimulus(32'd3, 32'd200, 32'd24, 16'd0, 1'b0);
    applyStimulus(32'd3, 32'd200, 32'd0, 16'd0, 1'b1);
    applyStimulus(32'd3, 32'd200, 32'd0, 16'd0, 1'b0);
    applyStimulus(32'd3, 32'd499, 32'd0, 16'd0, 1'b0);
    checkOutput("pre_expiry_state", 32'(bus.state), 32'd2);
    applyStimulus(32'd3, 32'd500, 32'd0, 16'd0, 1'b0);
    checkOutput("expiry_state", 32'(bus.state), 32'd3);
    checkOutput("expiry_pulse", 32'(bus.expired), 32'd1);
    applyStimulus(32'd3, 32'd500, 32'd0, 16'd0, 1'b0);
    checkOutput("post_expiry_state", 32'(bus.state), 32'd0);
    checkOutput("post_expiry_pulse", 32'(bus.expired), 32'd0);

    // Screen exit mid-ACTIVE with slow
    applyStimulus(32'd3, 32'd6, 32'd49, 16'd0, 1'b1);
    applyStimulus(32'd3, 32'd6, 32'd0, 16'd0, 1'b0);
    checkOutput("slow_active", 32'(bus.active_flags), 32'b010);
    applyStimulus(32'd1, 32'd6, 32'd0, 16'd0, 1'b0);
    checkOutput("exit_state", 32'(bus.state), 32'd0);
    checkOutput("exit_no_pulse", 32'(bus.expired), 32'd0);

    // Offer check coinciding with screen exit, then clicks wrap arming ycontrol
    applyStimulus(32'd1, 32'd7, 32'd24, 16'd0, 1'b1);
    applyStimulus(32'd3, 32'd7, 32'hFFFF_FFFF, 16'd0, 1'b1);
    checkOutput("wrap_offer", 32'(bus.offer_flags), 32'b100);
    applyStimulus(32'd3, 32'd5, 32'd24, 16'd0, 1'b1);
    applyStimulus(32'd0, 32'd5, 32'd0, 16'd0, 1'b1);

    // Winner latch: load, equal ignored, higher replaces, lower ignored
    applyStimulus(32'd4, 32'h0A00, 32'd0, 16'h4100, 1'b1);
    checkOutput("win_score", 32'(bus.winner_score), 32'h14);
    checkOutput("win_name", 32'(bus.winner_name), 32'h4100);
    applyStimulus(32'd4, 32'h0A00, 32'd0, 16'h4200, 1'b1);
    checkOutput("win_equal_name", 32'(bus.winner_name), 32'h4100);
    applyStimulus(32'd4, 32'h0A80, 32'd0, 16'h4300, 1'b1);
    checkOutput("win_higher", 32'(bus.winner_score), 32'h15);
    applyStimulus(32'd4, 32'h0500, 32'd0, 16'h4400, 1'b1);

`ifdef POWERUP_TIMEOUT_EN
    // Unclaimed offer is withdrawn after 8 ARMED cycles
    applyStimulus(32'd3, 32'd5, 32'd24, 16'd0, 1'b1);
    for (int i = 0; i < MODEL_ARM_TIMEOUT - 1; i++)
      applyStimulus(32'd3, 32'd5, 32'd0, 16'd0, 1'b1);
    checkOutput("to_still_armed", 32'(bus.state), 32'd1);
    applyStimulus(32'd3, 32'd5, 32'd0, 16'd0, 1'b1);
    checkOutput("to_idle", 32'(bus.state), 32'd0);
    checkOutput("to_offer_clear", 32'(bus.offer_flags), 32'd0);
    checkOutput("to_no_pulse", 32'(bus.expired), 32'd0);
    // Pickup edge on the terminal cycle wins
    applyStimulus(32'd3, 32'd5, 32'd24, 16'd0, 1'b1);
    for (int i = 0; i < MODEL_ARM_TIMEOUT - 1; i++)
      applyStimulus(32'd3, 32'd5, 32'd0, 16'd0, 1'b1);
    applyStimulus(32'd3, 32'd5, 32'd0, 16'd0, 1'b0);
    checkOutput("to_edge_wins", 32'(bus.state), 32'd2);
    applyStimulus(32'd0, 32'd5, 32'd0, 16'd0, 1'b1);
`endif

    // Random phase
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      scr = (r == 0) ? 32'd1 : (r == 1) ? 32'd4 : 32'd3;
      r = int'($urandom_range(0, 4));
      ck = (r == 0) ? 32'd24 : (r == 1) ? 32'd49 :
           (r == 2) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 60));
      applyStimulus(scr, 32'($urandom_range(0, 4095)), ck,
                    16'($urandom), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-ACTIVE
    applyStimulus(32'd3, 32'd5, 32'd24, 16'd0, 1'b1);
    applyStimulus(32'd3, 32'd100, 32'd0, 16'd0, 1'b1);
    applyStimulus(32'd3, 32'd100, 32'd0, 16'd0, 1'b0);
    checkOutput("pre_reset_state", 32'(bus.state), 32'd2);
    @(negedge clock);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_state", 32'(bus.state), 32'd0);
    checkOutput("async_power", 32'(bus.power_on), 32'd0);
    checkOutput("async_active", 32'(bus.active_flags), 32'd0);
    checkOutput("async_winner", 32'(bus.winner_score), 32'd0);
    checkOutput("async_name", 32'(bus.winner_name), 32'd0);
    modelReset();
    @(negedge clock);
    resetn = 1'b1;
    applyStimulus(32'd3, 32'd100, 32'd0, 16'd0, 1'b1);
    checkOutput("post_reset_state", 32'(bus.state), 32'd0);
    checkOutput("post_reset_winner", 32'(bus.winner_score), 32'd0);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/powerup_manager.md
Name: powerup_manager

Overview:
- Power-up sequencer between the register file (score, click count, screen state) and the VGA, regfile and audio consumers.
- Offers a power-up based on score and click cadence. Activates it when the VGA pickup strobe reports the bird touching the icon, and holds it for a fixed score span.
- Also latches the best end-of-game score and player name for the LCD stage.

Parameters:
- CLICK_MOD, 25, offer check fires when (clicks+1) mod CLICK_MOD == 0
- DURATION, 400, score units a power-up stays active
- SCREEN_GAME, 3, screen_state value for in-game
- SCREEN_END, 4, screen_state value for end screen
- ARM_TIMEOUT, 20000000, clock cycles an offer waits for pickup (optional feature only)

Ports:
- clock  in  1  system clock (10 MHz PLL domain)
- resetn  in  1  asynchronous active-low reset
- screen_state  in  32  regfile r28
- score  in  32  regfile r16, unsigned
- clicks  in  32  regfile r26, button click count
- name  in  16  player initials {letter, 8'h00}
- pickup_n  in  1  VGA trigger, active-low level
- power_on  out  1  icon visible / offer pending or in use
- offer_flags  out  3  one-hot offered power {ycontrol, slow, bounce}
- active_flags  out  3  one-hot active power {ycontrol, slow, bounce}; drives regfile and audio
- state  out  2  0 IDLE, 1 ARMED, 2 ACTIVE, 3 EXPIRED
- expired  out  1  one-cycle pulse on expiry
- winner_score  out  8  best score[14:7] seen at end screen
- winner_name  out  16  name latched with winner_score

Behaviour:
- Reset (async, resetn=0): all outputs 0, state IDLE, pickup history register = 1, start_score = 0.
- All other logic is synchronous on posedge clock. All outputs are registered, with 1-cycle latency from input to output.
- Priority 1: screen_state != SCREEN_GAME.
  - Force IDLE; clear power_on, offer_flags, active_flags, expired.
  - If screen_state == SCREEN_END and score[14:7] > winner_score (unsigned, strict): load winner_score = score[14:7] and winner_name = name in the same cycle. Equal scores do not replace the winner.
  - Winner registers clear only on reset.
- IDLE:
  - Check condition: (clicks+1), computed in 32 bits with wrap, mod CLICK_MOD == 0.
  - When the check holds and score[1:0] != 0, go to ARMED, set power_on = 1, and set offer_flags by score[1:0]: 1 → 3'b001 (bounce), 2 → 3'b010 (slow), 3 → 3'b100 (ycontrol).
  - score[1:0] == 0: stay IDLE.
- ARMED:
  - A falling edge of pickup_n (history 1, current 0) moves to ACTIVE. On that edge: active_flags ← offer_flags, start_score ← score.
  - A level-low pickup_n without an edge does nothing. The history register updates every cycle.
  - Further offer checks are ignored; the offer is never replaced.
- ACTIVE:
  - Compare zero-extended 33-bit score >= start_score + DURATION, with no wrap.
  - When true, go to EXPIRED; clear offer_flags, active_flags and power_on; pulse expired = 1.
  - Additional pickup edges are ignored.
- EXPIRED: lasts exactly one cycle, then IDLE. expired returns to 0.
- A screen_state change overrides any state in the same cycle, including mid-ACTIVE. An offer check and a screen exit in the same cycle resolve to the screen exit.
- At most one bit of offer_flags and of active_flags is ever set.

Optional Feature:
- Macro POWERUP_TIMEOUT_EN.
- Defined:
  - A 32-bit cycle counter clears on entry to ARMED and increments each ARMED cycle.
  - When it reaches ARM_TIMEOUT-1 without a pickup edge, return to IDLE and clear power_on and offer_flags; expired is not pulsed.
  - A pickup edge on the terminal cycle wins (go to ACTIVE).
- Undefined: no counter is built; ARMED persists until pickup or screen exit.

Test Plan:
- Reset: resetn low mid-ACTIVE → all outputs 0 immediately (asynchronously); after release, state=0, winner_score=0.
- Arm: screen_state=3, score=5, clicks=24 → next cycle state=1, power_on=1, offer_flags=001. Same stimulus with score=4 → state stays 0.
- Pickup and expiry:
  - pickup_n 1→0 at score=100 → state=2, active_flags=001.
  - Hold pickup_n=0 → no retrigger.
  - score=499 → still ACTIVE; score=500 → state=3, expired pulse, flags cleared; next cycle state=0.
- Screen exit: screen_state 3→1 while ACTIVE with slow (score=6 at arm) → next cycle state=0, active_flags=000, no expired pulse.
- Winner latch:
  - screen_state=4, score=0x0A00, name=0x4100 → winner_score=0x14, winner_name=0x4100.
  - Then score=0x0A00 with name=0x4200 → unchanged (equal).
  - score=0x0A80 → winner_score=0x15.
- Timeout (POWERUP_TIMEOUT_EN, ARM_TIMEOUT=8): arm, no pickup → IDLE after 8 ARMED cycles, offer cleared. Pickup edge on the 8th cycle → ACTIVE.
